// File: rtl/lap_stopwatch_pkg.sv
// Shared FSM encodings, display-source encodings and width helper for the lap stopwatch.
package lap_stopwatch_pkg;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  typedef enum logic [1:0] {
    SrcLive   = 2'd0,
    SrcLap    = 2'd1,
    SrcRecall = 2'd2
  } disp_src_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Key inputs and display/status outputs of the lap stopwatch, grouped as one bundle.
interface lap_stopwatch_if #(
  parameter int unsigned CNT_W     = 19,
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned LED_W     = 10
);
  import lap_stopwatch_pkg::*;

  localparam int unsigned IDX_W = bits(LAP_DEPTH - 1);
  localparam int unsigned LC_W  = bits(LAP_DEPTH);

  logic             key_start_n;
  logic             key_pause_n;
  logic             key_lap_n;
  logic             key_recall_n;
  logic [CNT_W-1:0] time_display;
  logic [1:0]       disp_src;
  logic [IDX_W-1:0] lap_idx;
  logic [LC_W-1:0]  lap_count;
  logic             lap_full;
  logic             wrapped;
  logic             running;
  logic             paused;
  logic [LED_W-1:0] led;

  modport master (
    output key_start_n, key_pause_n, key_lap_n, key_recall_n,
    input  time_display, disp_src, lap_idx, lap_count, lap_full, wrapped, running, paused, led
  );

  modport slave (
    input  key_start_n, key_pause_n, key_lap_n, key_recall_n,
    output time_display, disp_src, lap_idx, lap_count, lap_full, wrapped, running, paused, led
  );

endinterface

// File: rtl/lap_stopwatch_key_pulse.sv
// Active-low key to one-cycle press pulse: 2-FF sync, optional debounce, falling-edge detect.
// Debounce is built only when SW_DEBOUNCE_EN is defined.
module lap_stopwatch_key_pulse
`ifdef SW_DEBOUNCE_EN
  #(parameter int unsigned DEB_CYC = 1_000_000)
`endif
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pulse
);

  logic r_s1, r_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_key_n;
      r_s2 <= r_s1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned DW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

  logic [DW-1:0] r_cnt;
  logic          r_lvl;

  // r_lvl only follows the synced key once it has held a new level for DEB_CYC cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_lvl <= 1'b1;
    end else if (r_s2 == r_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == DW'(DEB_CYC - 1)) begin
      r_lvl <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

  assign o_pulse = r_lvl & ~r_s2 & (r_cnt == DW'(DEB_CYC - 1));
`else
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s3 <= 1'b1;
    end else begin
      r_s3 <= r_s2;
    end
  end

  assign o_pulse = r_s3 & ~r_s2;
`endif

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch core with lap buffer, recall browsing and one-hot seconds LED spot.
// Optional key debounce (20 ms) is enabled by defining SW_DEBOUNCE_EN.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned MAX_TICKS = 360000,
  parameter int unsigned CNT_W     = 19,
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned LED_W     = 10
) (
  input logic            i_clk,
  input logic            i_rst,
  lap_stopwatch_if.slave sw
);

  localparam int unsigned PRE_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int unsigned PRE_W   = bits(PRE_MAX);
  localparam int unsigned SUB_W   = bits(TICK_HZ - 1);
  localparam int unsigned SEC_W   = bits(LED_W - 1);
  localparam int unsigned IDX_W   = bits(LAP_DEPTH - 1);
  localparam int unsigned LC_W    = bits(LAP_DEPTH);
`ifdef SW_DEBOUNCE_EN
  localparam int unsigned DEB_CYC = CLK_HZ / 50;
`endif

  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_cnt, r_disp, w_disp_sel;
  logic [SUB_W-1:0] r_sub;
  logic [SEC_W-1:0] r_sec;
  logic [LC_W-1:0]  r_lap_cnt;
  logic [IDX_W-1:0] r_idx, w_last_idx, w_wr_idx;
  disp_src_e        r_src;
  logic             r_full, r_wrap;
  logic [CNT_W-1:0] r_lap [LAP_DEPTH];
  logic [3:0]       w_key_n, w_press;
  logic             w_do_start, w_do_pause, w_do_lap, w_do_recall;
  logic             w_run, w_tick, w_lap_ok;

  assign w_key_n = {sw.key_recall_n, sw.key_lap_n, sw.key_pause_n, sw.key_start_n};

  for (genvar g = 0; g < 4; g++) begin : g_key
`ifdef SW_DEBOUNCE_EN
    lap_stopwatch_key_pulse #(.DEB_CYC(DEB_CYC)) u_key (
      .i_clk(i_clk), .i_rst(i_rst), .i_key_n(w_key_n[g]), .o_pulse(w_press[g])
    );
`else
    lap_stopwatch_key_pulse u_key (
      .i_clk(i_clk), .i_rst(i_rst), .i_key_n(w_key_n[g]), .o_pulse(w_press[g])
    );
`endif
  end

  // Only the highest-priority press in a cycle takes effect.
  assign w_do_start  = w_press[0];
  assign w_do_pause  = w_press[1] & ~w_press[0];
  assign w_do_lap    = w_press[2] & ~|w_press[1:0];
  assign w_do_recall = w_press[3] & ~|w_press[2:0];

  assign w_run      = (r_state == ST_RUN);
  assign w_tick     = w_run & ~w_do_start & (r_pre == PRE_W'(PRE_MAX));
  assign w_last_idx = IDX_W'(r_lap_cnt - LC_W'(1));
  assign w_wr_idx   = IDX_W'(r_lap_cnt);
  assign w_lap_ok   = w_do_lap & w_run & (r_lap_cnt < LC_W'(LAP_DEPTH));

  always_comb begin
    w_disp_sel = r_cnt;
    unique case (r_src)
      SrcLap:    w_disp_sel = r_lap[w_last_idx];
      SrcRecall: w_disp_sel = r_lap[r_idx];
      default:   w_disp_sel = r_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_lap_ok) begin
      r_lap[w_wr_idx] <= r_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_STOP;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_sub     <= '0;
      r_sec     <= '0;
      r_lap_cnt <= '0;
      r_idx     <= '0;
      r_src     <= SrcLive;
      r_full    <= 1'b0;
      r_wrap    <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_disp <= w_disp_sel;
      if (w_tick) begin
        r_pre <= '0;
        if (r_cnt == CNT_W'(MAX_TICKS - 1)) begin
          r_cnt  <= '0;
          r_sub  <= '0;
          r_sec  <= '0;
          r_wrap <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_sub == SUB_W'(TICK_HZ - 1)) begin
            r_sub <= '0;
            r_sec <= (r_sec == SEC_W'(LED_W - 1)) ? '0 : r_sec + SEC_W'(1);
          end else begin
            r_sub <= r_sub + SUB_W'(1);
          end
        end
      end else if (w_run && !w_do_start) begin
        r_pre <= r_pre + PRE_W'(1);
      end

      if (w_do_start) begin
        r_cnt <= '0;
        r_pre <= '0;
        r_sub <= '0;
        r_sec <= '0;
        r_src <= SrcLive;
        if (r_state == ST_STOP) begin
          r_state   <= ST_RUN;
          r_lap_cnt <= '0;
          r_idx     <= '0;
          r_full    <= 1'b0;
          r_wrap    <= 1'b0;
        end else begin
          r_state <= ST_STOP;
        end
      end else if (w_do_pause) begin
        if (w_run) begin
          r_state <= ST_PAUSE;
        end else if (r_state == ST_PAUSE) begin
          r_state <= ST_RUN;
          r_src   <= SrcLive;
        end
      end else if (w_do_lap && w_run) begin
        if (w_lap_ok) begin
          r_lap_cnt <= r_lap_cnt + LC_W'(1);
          r_src     <= SrcLap;
        end else begin
          r_full <= 1'b1;
        end
      end else if (w_do_recall) begin
        if (w_run) begin
          if (r_src == SrcLap) r_src <= SrcLive;
        end else if (r_lap_cnt != '0) begin
          r_src <= SrcRecall;
          if (r_src != SrcRecall || r_idx == w_last_idx) r_idx <= '0;
          else r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    sw.led = '0;
    if (r_state != ST_STOP) sw.led = LED_W'(1) << (SEC_W'(LED_W - 1) - r_sec);
  end

  assign sw.time_display = r_disp;
  assign sw.disp_src     = r_src;
  assign sw.lap_idx      = r_idx;
  assign sw.lap_count    = r_lap_cnt;
  assign sw.lap_full     = r_full;
  assign sw.wrapped      = r_wrap;
  assign sw.running      = (r_state == ST_RUN);
  assign sw.paused       = (r_state == ST_PAUSE);

endmodule
